// File: rtl/adma_pkg.sv
// Shared constants, register map and FSM state encoding for the ADMA
// descriptor programmer.
package adma_pkg;

  // CSR bank offsets relative to the slave base address
  localparam logic [31:0] RW_BANK_OFS   = 32'h0000_0000;
  localparam logic [31:0] RW1S_BANK_OFS = 32'h0000_1000;
  localparam logic [31:0] RO_BANK_OFS   = 32'h0000_2000;

  // Each channel owns a block of 16 word-indexed registers
  localparam logic [31:0] CHN_STRIDE = 32'd16;

  // Register indices inside a channel block
  localparam logic [31:0] REG_SRC_ADDR = 32'h09;
  localparam logic [31:0] REG_DST_ADDR = 32'h0A;
  localparam logic [31:0] REG_XLEN     = 32'h0B;
  localparam logic [31:0] REG_YLEN     = 32'h0C;
  localparam logic [31:0] REG_SRC_STRD = 32'h0D;
  localparam logic [31:0] REG_DST_STRD = 32'h0E;
  localparam logic [31:0] REG_PUSH     = 32'h00;
  localparam logic [31:0] REG_XFER_ID  = 32'h01;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Config burst carries six beats, numbered 0..5
  localparam logic [2:0] CFG_LAST_BEAT = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CFG_AW = 4'd1,
    ST_CFG_W  = 4'd2,
    ST_CFG_B  = 4'd3,
    ST_PSH_AW = 4'd4,
    ST_PSH_W  = 4'd5,
    ST_PSH_B  = 4'd6,
    ST_ID_AR  = 4'd7,
    ST_ID_R   = 4'd8,
    ST_CPL    = 4'd9
  } state_e;

  // Word address of register idx in a given bank of a given channel
  function automatic logic [31:0] csr_addr(input logic [31:0] base,
                                           input logic [31:0] bank,
                                           input logic [31:0] chn,
                                           input logic [31:0] idx);
    return base + bank + (chn * CHN_STRIDE) + idx;
  endfunction

endpackage

// File: rtl/adma_desc_prog.sv
// AXI4 initiator that writes one DMA descriptor into the ADMA CSR slave,
// pushes it, reads back the assigned transfer ID and reports a completion.
//
// Handshakes: every channel (req, cpl, AW, W, B, AR, R) transfers on a cycle
// where valid and ready are both high at the rising clock edge; a source
// never drops valid or changes payload while waiting for ready, and ready
// never depends combinationally on valid. All outputs here are registers.
module adma_desc_prog
  import adma_pkg::*;
#(
  parameter logic [31:0] DMA_BASE_ADDR  = 32'h8000_0000,
  parameter int          DMA_CHN_NUM    = 4,
  parameter int          DMA_DESC_DEPTH = 4,
  parameter int          DMA_LENGTH_W   = 16,
  parameter int          SRC_ADDR_W     = 32,
  parameter int          DST_ADDR_W     = 32,
  parameter int          M_DATA_W       = 32,
  parameter int          M_ADDR_W       = 32,
  parameter int          MST_ID_W       = 5,
  parameter int          ATX_LEN_W      = 8,
  parameter int          ATX_RESP_W     = 2,
  parameter int unsigned PROG_ID        = 0,
  localparam int CHN_W         = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
  localparam int DMA_XFER_ID_W = (DMA_DESC_DEPTH > 1) ? $clog2(DMA_DESC_DEPTH) : 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  // descriptor request
  input  logic                     req_vld_i,
  output logic                     req_rdy_o,
  input  logic [CHN_W-1:0]         req_chn_i,
  input  logic [SRC_ADDR_W-1:0]    req_src_addr_i,
  input  logic [DST_ADDR_W-1:0]    req_dst_addr_i,
  input  logic [DMA_LENGTH_W-1:0]  req_xlen_i,
  input  logic [DMA_LENGTH_W-1:0]  req_ylen_i,
  input  logic [DMA_LENGTH_W-1:0]  req_src_strd_i,
  input  logic [DMA_LENGTH_W-1:0]  req_dst_strd_i,
  // completion
  output logic                     cpl_vld_o,
  input  logic                     cpl_rdy_i,
  output logic [DMA_XFER_ID_W-1:0] cpl_xfer_id_o,
  output logic                     cpl_err_o,
  // AXI write address
  output logic [MST_ID_W-1:0]      m_awid_o,
  output logic [M_ADDR_W-1:0]      m_awaddr_o,
  output logic [ATX_LEN_W-1:0]     m_awlen_o,
  output logic                     m_awvalid_o,
  input  logic                     m_awready_i,
  // AXI write data
  output logic [M_DATA_W-1:0]      m_wdata_o,
  output logic                     m_wlast_o,
  output logic                     m_wvalid_o,
  input  logic                     m_wready_i,
  // AXI write response
  input  logic [MST_ID_W-1:0]      m_bid_i,
  input  logic [ATX_RESP_W-1:0]    m_bresp_i,
  input  logic                     m_bvalid_i,
  output logic                     m_bready_o,
  // AXI read address
  output logic [MST_ID_W-1:0]      m_arid_o,
  output logic [M_ADDR_W-1:0]      m_araddr_o,
  output logic [ATX_LEN_W-1:0]     m_arlen_o,
  output logic                     m_arvalid_o,
  input  logic                     m_arready_i,
  // AXI read data
  input  logic [MST_ID_W-1:0]      m_rid_i,
  input  logic [M_DATA_W-1:0]      m_rdata_i,
  input  logic [ATX_RESP_W-1:0]    m_rresp_i,
  input  logic                     m_rlast_i,
  input  logic                     m_rvalid_i,
  output logic                     m_rready_o
);

  // FSM and latched request
  state_e                   state_q, state_d;
  logic [2:0]               beat_q, beat_d;
  logic                     err_q, err_d;
  logic [DMA_XFER_ID_W-1:0] xfer_id_q, xfer_id_d;
  logic [CHN_W-1:0]         chn_q, chn_d;
  logic [SRC_ADDR_W-1:0]    src_q, src_d;
  logic [DST_ADDR_W-1:0]    dst_q, dst_d;
  logic [DMA_LENGTH_W-1:0]  xlen_q, xlen_d;
  logic [DMA_LENGTH_W-1:0]  ylen_q, ylen_d;
  logic [DMA_LENGTH_W-1:0]  sstrd_q, sstrd_d;
  logic [DMA_LENGTH_W-1:0]  dstrd_q, dstrd_d;

  // Registered interface outputs
  logic                     req_rdy_q, req_rdy_d;
  logic                     awvalid_q, awvalid_d;
  logic [M_ADDR_W-1:0]      awaddr_q, awaddr_d;
  logic [ATX_LEN_W-1:0]     awlen_q, awlen_d;
  logic                     wvalid_q, wvalid_d;
  logic [M_DATA_W-1:0]      wdata_q, wdata_d;
  logic                     wlast_q, wlast_d;
  logic                     bready_q, bready_d;
  logic                     arvalid_q, arvalid_d;
  logic [M_ADDR_W-1:0]      araddr_q, araddr_d;
  logic                     rready_q, rready_d;
  logic                     cpl_vld_q, cpl_vld_d;

  // Response IDs and the upper read-data bits carry nothing we need
  logic unused_inputs;
  assign unused_inputs = ^{m_bid_i, m_rid_i, m_rdata_i[M_DATA_W-1:DMA_XFER_ID_W]};

  // Sequence control: advance on each handshake, collect errors and the ID
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    err_d     = err_q;
    xfer_id_d = xfer_id_q;
    chn_d     = chn_q;
    src_d     = src_q;
    dst_d     = dst_q;
    xlen_d    = xlen_q;
    ylen_d    = ylen_q;
    sstrd_d   = sstrd_q;
    dstrd_d   = dstrd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_vld_i && req_rdy_q) begin
          chn_d     = req_chn_i;
          src_d     = req_src_addr_i;
          dst_d     = req_dst_addr_i;
          xlen_d    = req_xlen_i;
          ylen_d    = req_ylen_i;
          sstrd_d   = req_src_strd_i;
          dstrd_d   = req_dst_strd_i;
          err_d     = 1'b0;
          xfer_id_d = '0;
          beat_d    = 3'd0;
          state_d   = ST_CFG_AW;
        end
      end
      ST_CFG_AW: begin
        if (awvalid_q && m_awready_i) state_d = ST_CFG_W;
      end
      ST_CFG_W: begin
        if (wvalid_q && m_wready_i) begin
          if (beat_q == CFG_LAST_BEAT) begin
            beat_d  = 3'd0;
            state_d = ST_CFG_B;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      ST_CFG_B: begin
        if (bready_q && m_bvalid_i) begin
          // A rejected config must not be pushed; report straight away
          if (m_bresp_i != ATX_RESP_W'(RESP_OKAY)) begin
            err_d   = 1'b1;
            state_d = ST_CPL;
          end else begin
            state_d = ST_PSH_AW;
          end
        end
      end
      ST_PSH_AW: begin
        if (awvalid_q && m_awready_i) state_d = ST_PSH_W;
      end
      ST_PSH_W: begin
        if (wvalid_q && m_wready_i) state_d = ST_PSH_B;
      end
      ST_PSH_B: begin
        if (bready_q && m_bvalid_i) begin
          if (m_bresp_i != ATX_RESP_W'(RESP_OKAY)) err_d = 1'b1;
          state_d = ST_ID_AR;
        end
      end
      ST_ID_AR: begin
        if (arvalid_q && m_arready_i) state_d = ST_ID_R;
      end
      ST_ID_R: begin
        if (rready_q && m_rvalid_i) begin
          xfer_id_d = m_rdata_i[DMA_XFER_ID_W-1:0];
          if (m_rresp_i != ATX_RESP_W'(RESP_OKAY)) err_d = 1'b1;
          if (m_rlast_i) state_d = ST_CPL;
        end
      end
      ST_CPL: begin
        if (cpl_vld_q && cpl_rdy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a plain register
  always_comb begin
    req_rdy_d = (state_d == ST_IDLE);
    awvalid_d = (state_d == ST_CFG_AW) || (state_d == ST_PSH_AW);
    awaddr_d  = '0;
    awlen_d   = '0;
    if (state_d == ST_CFG_AW) begin
      awaddr_d = M_ADDR_W'(csr_addr(DMA_BASE_ADDR, RW_BANK_OFS, 32'(chn_d), REG_SRC_ADDR));
      awlen_d  = ATX_LEN_W'(CFG_LAST_BEAT);
    end else if (state_d == ST_PSH_AW) begin
      awaddr_d = M_ADDR_W'(csr_addr(DMA_BASE_ADDR, RW1S_BANK_OFS, 32'(chn_d), REG_PUSH));
    end
    wvalid_d = (state_d == ST_CFG_W) || (state_d == ST_PSH_W);
    wdata_d  = '0;
    if (state_d == ST_CFG_W) begin
      case (beat_d)
        3'd0:    wdata_d = M_DATA_W'(src_d);
        3'd1:    wdata_d = M_DATA_W'(dst_d);
        3'd2:    wdata_d = M_DATA_W'(xlen_d);
        3'd3:    wdata_d = M_DATA_W'(ylen_d);
        3'd4:    wdata_d = M_DATA_W'(sstrd_d);
        default: wdata_d = M_DATA_W'(dstrd_d);
      endcase
    end else if (state_d == ST_PSH_W) begin
      wdata_d = M_DATA_W'(1);
    end
    wlast_d   = ((state_d == ST_CFG_W) && (beat_d == CFG_LAST_BEAT)) || (state_d == ST_PSH_W);
    bready_d  = (state_d == ST_CFG_B) || (state_d == ST_PSH_B);
    arvalid_d = (state_d == ST_ID_AR);
    araddr_d  = '0;
    if (state_d == ST_ID_AR) begin
      araddr_d = M_ADDR_W'(csr_addr(DMA_BASE_ADDR, RO_BANK_OFS, 32'(chn_d), REG_XFER_ID));
    end
    rready_d  = (state_d == ST_ID_R);
    cpl_vld_d = (state_d == ST_CPL);
  end

  // State, request latch and output registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      beat_q    <= 3'd0;
      err_q     <= 1'b0;
      xfer_id_q <= '0;
      chn_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      xlen_q    <= '0;
      ylen_q    <= '0;
      sstrd_q   <= '0;
      dstrd_q   <= '0;
      req_rdy_q <= 1'b1;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
      cpl_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      xfer_id_q <= xfer_id_d;
      chn_q     <= chn_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      xlen_q    <= xlen_d;
      ylen_q    <= ylen_d;
      sstrd_q   <= sstrd_d;
      dstrd_q   <= dstrd_d;
      req_rdy_q <= req_rdy_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= rready_d;
      cpl_vld_q <= cpl_vld_d;
    end
  end

  assign req_rdy_o     = req_rdy_q;
  assign cpl_vld_o     = cpl_vld_q;
  assign cpl_xfer_id_o = xfer_id_q;
  assign cpl_err_o     = err_q;
  assign m_awid_o      = MST_ID_W'(PROG_ID);
  assign m_awaddr_o    = awaddr_q;
  assign m_awlen_o     = awlen_q;
  assign m_awvalid_o   = awvalid_q;
  assign m_wdata_o     = wdata_q;
  assign m_wlast_o     = wlast_q;
  assign m_wvalid_o    = wvalid_q;
  assign m_bready_o    = bready_q;
  assign m_arid_o      = MST_ID_W'(PROG_ID);
  assign m_araddr_o    = araddr_q;
  assign m_arlen_o     = '0;
  assign m_arvalid_o   = arvalid_q;
  assign m_rready_o    = rready_q;

endmodule

// File: tb/tb_adma_desc_prog.sv
// Directed bench for adma_desc_prog: a sequential AXI slave model driven
// from tasks, a protocol monitor, and an expected-ID queue.
module tb_adma_desc_prog;

  localparam int TMO = 200;

  // ---------------- clock / reset ----------------
  logic        aclk = 1'b0;
  logic        areset;
  always #5 aclk = ~aclk;

  logic        req_vld_i, req_rdy_o;
  logic [1:0]  req_chn_i;
  logic [31:0] req_src_addr_i, req_dst_addr_i;
  logic [15:0] req_xlen_i, req_ylen_i, req_src_strd_i, req_dst_strd_i;
  logic        cpl_vld_o, cpl_rdy_i;
  logic [1:0]  cpl_xfer_id_o;
  logic        cpl_err_o;
  logic [4:0]  m_awid_o, m_arid_o, m_bid_i, m_rid_i;
  logic [31:0] m_awaddr_o, m_araddr_o, m_wdata_o, m_rdata_i;
  logic [7:0]  m_awlen_o, m_arlen_o;
  logic        m_awvalid_o, m_awready_i, m_wlast_o, m_wvalid_o, m_wready_i;
  logic [1:0]  m_bresp_i, m_rresp_i;
  logic        m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i;
  logic        m_rlast_i, m_rvalid_i, m_rready_o;

  adma_desc_prog dut (
    .aclk(aclk), .areset(areset),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_chn_i(req_chn_i),
    .req_src_addr_i(req_src_addr_i), .req_dst_addr_i(req_dst_addr_i),
    .req_xlen_i(req_xlen_i), .req_ylen_i(req_ylen_i),
    .req_src_strd_i(req_src_strd_i), .req_dst_strd_i(req_dst_strd_i),
    .cpl_vld_o(cpl_vld_o), .cpl_rdy_i(cpl_rdy_i),
    .cpl_xfer_id_o(cpl_xfer_id_o), .cpl_err_o(cpl_err_o),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i),
    .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i),
    .m_bready_o(m_bready_o),
    .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
    .m_rlast_i(m_rlast_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         abort    = 1'b0;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- protocol monitor ----------------
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, viol = 0;
  logic        p_rst = 1'b1;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_cv, p_cr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [7:0]  p_awlen;
  logic        p_wlast, p_cerr;
  logic [1:0]  p_cid;

  always @(posedge aclk) begin
    if (areset) begin
      p_rst <= 1'b1;
    end else begin
      if (m_awvalid_o && m_awready_i) aw_hs <= aw_hs + 1;
      if (m_wvalid_o && m_wready_i)   w_hs  <= w_hs + 1;
      if (m_arvalid_o && m_arready_i) ar_hs <= ar_hs + 1;
      if (m_bvalid_i && m_bready_o)   b_hs  <= b_hs + 1;
      if (m_rvalid_i && m_rready_o)   r_hs  <= r_hs + 1;
      if (m_awvalid_o && m_wvalid_o)  viol  <= viol + 1;
      if (!p_rst) begin
        if (p_awv && !p_awr && (!m_awvalid_o || m_awaddr_o !== p_awaddr || m_awlen_o !== p_awlen))
          viol <= viol + 1;
        if (p_wv && !p_wr && (!m_wvalid_o || m_wdata_o !== p_wdata || m_wlast_o !== p_wlast))
          viol <= viol + 1;
        if (p_arv && !p_arr && (!m_arvalid_o || m_araddr_o !== p_araddr))
          viol <= viol + 1;
        if (p_cv && !p_cr && (!cpl_vld_o || cpl_xfer_id_o !== p_cid || cpl_err_o !== p_cerr))
          viol <= viol + 1;
      end
      p_rst <= 1'b0;
    end
    p_awv <= m_awvalid_o; p_awr <= m_awready_i; p_awaddr <= m_awaddr_o; p_awlen <= m_awlen_o;
    p_wv  <= m_wvalid_o;  p_wr  <= m_wready_i;  p_wdata  <= m_wdata_o;  p_wlast <= m_wlast_o;
    p_arv <= m_arvalid_o; p_arr <= m_arready_i; p_araddr <= m_araddr_o;
    p_cv  <= cpl_vld_o;   p_cr  <= cpl_rdy_i;   p_cid    <= cpl_xfer_id_o; p_cerr <= cpl_err_o;
  end

  // ---------------- driver tasks ----------------
  function automatic logic sig(input int k);
    case (k)
      0:       return m_awvalid_o;
      1:       return m_wvalid_o;
      2:       return m_bready_o;
      3:       return m_arvalid_o;
      4:       return m_rready_o;
      5:       return cpl_vld_o;
      default: return req_rdy_o;
    endcase
  endfunction

  task automatic wait_hi(input string tag, input int k);
    int n = 0;
    while (!sig(k) && n < TMO) begin
      @(negedge aclk);
      n++;
    end
    if (!sig(k)) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      abort = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    req_vld_i = 1'b0; req_chn_i = '0; req_src_addr_i = '0; req_dst_addr_i = '0;
    req_xlen_i = '0; req_ylen_i = '0; req_src_strd_i = '0; req_dst_strd_i = '0;
    cpl_rdy_i = 1'b0; m_awready_i = 1'b0; m_wready_i = 1'b0; m_arready_i = 1'b0;
    m_bid_i = '0; m_bresp_i = '0; m_bvalid_i = 1'b0;
    m_rid_i = '0; m_rdata_i = '0; m_rresp_i = '0; m_rlast_i = 1'b0; m_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic send_req(input logic [1:0] chn, input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] xl, input logic [15:0] yl,
                          input logic [15:0] ss, input logic [15:0] ds, input int smax);
    repeat ($urandom_range(smax, 0)) @(negedge aclk);
    req_chn_i = chn; req_src_addr_i = src; req_dst_addr_i = dst;
    req_xlen_i = xl; req_ylen_i = yl; req_src_strd_i = ss; req_dst_strd_i = ds;
    req_vld_i = 1'b1;
    wait_hi("req_rdy", 6);
    if (abort) return;
    @(negedge aclk);
    req_vld_i = 1'b0;
  endtask

  task automatic aw_accept(input string tag, input logic [31:0] addr, input logic [7:0] len, input int smax);
    wait_hi(tag, 0);
    if (abort) return;
    repeat ($urandom_range(smax, 0)) @(negedge aclk);
    chk({tag, "_awaddr"}, m_awaddr_o, addr);
    chk({tag, "_awlen"}, m_awlen_o, len);
    chk({tag, "_awid"}, m_awid_o, 0);
    chk({tag, "_w_with_aw"}, m_wvalid_o, 0);
    m_awready_i = 1'b1;
    @(negedge aclk);
    m_awready_i = 1'b0;
  endtask

  task automatic w_accept(input string tag, input logic [31:0] data, input logic last, input int smax);
    wait_hi(tag, 1);
    if (abort) return;
    repeat ($urandom_range(smax, 0)) @(negedge aclk);
    chk({tag, "_wdata"}, m_wdata_o, data);
    chk({tag, "_wlast"}, m_wlast_o, last);
    m_wready_i = 1'b1;
    @(negedge aclk);
    m_wready_i = 1'b0;
  endtask

  task automatic b_send(input string tag, input logic [1:0] resp, input int smax);
    repeat ($urandom_range(smax, 0)) @(negedge aclk);
    m_bvalid_i = 1'b1; m_bresp_i = resp; m_bid_i = 5'd0;
    wait_hi(tag, 2);
    if (abort) return;
    @(negedge aclk);
    m_bvalid_i = 1'b0; m_bresp_i = 2'b00;
  endtask

  task automatic run_req(input logic [1:0] chn, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] xl, input logic [15:0] yl,
                         input logic [15:0] ss, input logic [15:0] ds,
                         input logic [1:0] cfg_bresp, input logic [1:0] psh_bresp,
                         input logic [1:0] rid, input logic [1:0] rresp,
                         input int smax, input int hold);
    logic [31:0] beats[6];
    logic [31:0] cfg_addr, psh_addr, id_addr;
    logic        exp_err;
    int          aw0, ar0, aw1, ar1, w1;
    beats[0] = src; beats[1] = dst; beats[2] = {16'd0, xl};
    beats[3] = {16'd0, yl}; beats[4] = {16'd0, ss}; beats[5] = {16'd0, ds};
    cfg_addr = 32'h8000_0009 + {26'd0, chn, 4'd0};
    psh_addr = 32'h8000_1000 + {26'd0, chn, 4'd0};
    id_addr  = 32'h8000_2001 + {26'd0, chn, 4'd0};
    aw0 = aw_hs; ar0 = ar_hs;
    exp_err = (cfg_bresp != 2'b00);
    send_req(chn, src, dst, xl, yl, ss, ds, smax);
    if (abort) return;
    aw_accept("cfg", cfg_addr, 8'd5, smax);
    if (abort) return;
    for (int i = 0; i < 6; i++) begin
      w_accept("cfg", beats[i], (i == 5), smax);
      if (abort) return;
    end
    b_send("cfg_b", cfg_bresp, smax);
    if (abort) return;
    if (cfg_bresp == 2'b00) begin
      aw_accept("psh", psh_addr, 8'd0, smax);
      if (abort) return;
      w_accept("psh", 32'd1, 1'b1, smax);
      if (abort) return;
      b_send("psh_b", psh_bresp, smax);
      if (abort) return;
      wait_hi("id_ar", 3);
      if (abort) return;
      repeat ($urandom_range(smax, 0)) @(negedge aclk);
      chk("id_araddr", m_araddr_o, id_addr);
      chk("id_arlen", m_arlen_o, 0);
      chk("id_arid", m_arid_o, 0);
      m_arready_i = 1'b1;
      @(negedge aclk);
      m_arready_i = 1'b0;
      repeat ($urandom_range(smax, 0)) @(negedge aclk);
      m_rvalid_i = 1'b1; m_rlast_i = 1'b1; m_rresp_i = rresp; m_rid_i = 5'd0;
      m_rdata_i  = {30'($urandom), rid};
      wait_hi("id_r", 4);
      if (abort) return;
      @(negedge aclk);
      m_rvalid_i = 1'b0; m_rlast_i = 1'b0; m_rresp_i = 2'b00;
      exp_q.push_back(rid);
      exp_err = (psh_bresp != 2'b00) || (rresp != 2'b00);
    end
    wait_hi("cpl", 5);
    if (abort) return;
    if (hold > 0) begin
      aw1 = aw_hs; ar1 = ar_hs; w1 = w_hs;
      repeat (hold) @(negedge aclk);
      chk("hold_cpl_vld", cpl_vld_o, 1);
      chk("hold_req_rdy", req_rdy_o, 0);
      chk("hold_no_axi", {aw_hs - aw1, ar_hs - ar1, w_hs - w1}, 0);
      chk("hold_no_valid", {m_awvalid_o, m_wvalid_o, m_arvalid_o}, 0);
    end else begin
      repeat ($urandom_range(smax, 0)) @(negedge aclk);
    end
    chk("cpl_err", cpl_err_o, exp_err);
    if (cfg_bresp == 2'b00) chk("cpl_xfer_id", cpl_xfer_id_o, exp_q.pop_front());
    chk("aw_count", aw_hs - aw0, (cfg_bresp == 2'b00) ? 2 : 1);
    chk("ar_count", ar_hs - ar0, (cfg_bresp == 2'b00) ? 1 : 0);
    cpl_rdy_i = 1'b1;
    @(negedge aclk);
    cpl_rdy_i = 1'b0;
    chk("idle_after_cpl", {req_rdy_o, cpl_vld_o}, 2'b10);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b0;

    // reset values
    chk("rst_req_rdy", req_rdy_o, 1);
    chk("rst_valids", {m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o, cpl_vld_o}, 0);
    chk("rst_cpl", {cpl_xfer_id_o, cpl_err_o}, 0);
    chk("rst_aw", {m_awaddr_o, m_awlen_o}, 0);
    chk("rst_w", {m_wdata_o, m_wlast_o}, 0);
    chk("rst_ar", {m_araddr_o, m_arlen_o}, 0);

    // stray B/R beats in IDLE are not accepted
    m_bvalid_i = 1'b1; m_rvalid_i = 1'b1; m_rlast_i = 1'b1;
    @(negedge aclk);
    chk("idle_bready", m_bready_o, 0);
    chk("idle_rready", m_rready_o, 0);
    m_bvalid_i = 1'b0; m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
    @(negedge aclk);
    chk("idle_no_br_hs", {b_hs, r_hs}, 0);

    // single request, no stalls: AW 0x8000_0029, push 0x8000_1020, AR 0x8000_2021
    run_req(2'd2, 32'h1000_0000, 32'h2000_0000, 16'h0040, 16'h0001, 16'h0, 16'h0,
            2'b00, 2'b00, 2'd3, 2'b00, 0, 0);
    if (abort) do_reset();

    // 20 back-to-back requests, rotating channels, random stalls 0-5
    for (int i = 0; i < 20; i++) begin
      run_req(2'(i), $urandom, $urandom, 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 2'b00, 2'b00, 2'(i + 1), 2'b00, 5, 0);
      if (abort) do_reset();
    end

    // SLVERR on the config B: no push, no readback, error completion
    run_req(2'd1, 32'hAAAA_0000, 32'h5555_0000, 16'h0010, 16'h0002, 16'h0100, 16'h0200,
            2'b10, 2'b00, 2'd0, 2'b00, 1, 0);
    if (abort) do_reset();

    // SLVERR on readback: push done, ID still captured, error flagged
    run_req(2'd3, 32'h0000_1234, 32'h0000_5678, 16'h0008, 16'h0004, 16'h0020, 16'h0040,
            2'b00, 2'b00, 2'd1, 2'b10, 1, 0);
    if (abort) do_reset();

    // completion held off for 10 cycles
    run_req(2'd0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 16'hFFFF, 16'h0003, 16'h1111, 16'h2222,
            2'b00, 2'b00, 2'd2, 2'b00, 0, 10);
    if (abort) do_reset();

    // reset while config beat 3 is pending
    send_req(2'd1, 32'h0101_0101, 32'h0202_0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 0);
    if (!abort) aw_accept("rstseq", 32'h8000_0019, 8'd5, 0);
    if (!abort) w_accept("rstseq_b0", 32'h0101_0101, 1'b0, 0);
    if (!abort) w_accept("rstseq_b1", 32'h0202_0202, 1'b0, 0);
    if (!abort) w_accept("rstseq_b2", 32'h0000_0303, 1'b0, 0);
    if (!abort) wait_hi("rstseq_b3", 1);
    if (!abort) begin
      chk("rstseq_b3_wdata", m_wdata_o, 32'h0000_0404);
      areset = 1'b1;
      @(negedge aclk);
      chk("midrst_valids", {m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o, cpl_vld_o}, 0);
      chk("midrst_req_rdy", req_rdy_o, 1);
      chk("midrst_outs", {m_wdata_o, m_wlast_o, m_awaddr_o, cpl_xfer_id_o, cpl_err_o}, 0);
      areset = 1'b0;
    end else begin
      do_reset();
    end

    // fresh request after the mid-sequence reset
    run_req(2'd1, 32'h1357_9BDF, 32'h2468_ACE0, 16'h0100, 16'h0010, 16'h0004, 16'h0008,
            2'b00, 2'b00, 2'd2, 2'b00, 2, 0);
    if (abort) do_reset();

    repeat (2) @(negedge aclk);
    chk("protocol_violations", viol, 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
